// File: rtl/fusiont.sv
// fusiont: observer for the fused sequence start |=> a ##1 b ##1 c.
// Up to three overlapping attempts are tracked in a one-hot-per-stage
// pipeline (s1: waiting for a, s2: waiting for b, s3: waiting for c).
// Each completed attempt gives a pass pulse and each dropped attempt a fail
// pulse, and both kinds are tallied in saturating counters.
// Optional build macro: FUSIONT_ERR_STICKY_EN adds err_sticky and fail_stage.
module fusiont #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             pass,
    output logic             fail,
    output logic             active,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef FUSIONT_ERR_STICKY_EN
    ,
    output logic             err_sticky,
    output logic [1:0]       fail_stage
`endif
);

    // Adds a 0..3 increment to a counter and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                                 input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cur} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             f1_s, f2_s, f3_s;
    logic             done_s;
    logic [1:0]       fail_inc_s;

    // Check terms: a stage that sees its input low drops its attempt and flags a failure.
    always_comb begin
        f1_s       = s1_q & ~a;
        f2_s       = s2_q & ~b;
        f3_s       = s3_q & ~c;
        done_s     = s3_q & c;
        fail_inc_s = {1'b0, f1_s} + {1'b0, f2_s} + {1'b0, f3_s};
    end

    // Next state: advance surviving attempts, form the report pulses and counter updates.
    always_comb begin
        s1_d       = start;
        s2_d       = s1_q & a;
        s3_d       = s2_q & b;
        pass_d     = done_s;
        fail_d     = f1_s | f2_s | f3_s;
        pass_cnt_d = sat_add(pass_cnt_q, {1'b0, done_s});
        fail_cnt_d = sat_add(fail_cnt_q, fail_inc_s);
    end

    // State register; reset discards every in-flight attempt without reporting it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= {CNT_W{1'b0}};
            fail_cnt_q <= {CNT_W{1'b0}};
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

`ifdef FUSIONT_ERR_STICKY_EN
    logic       err_sticky_q, err_sticky_d;
    logic [1:0] fail_stage_q, fail_stage_d;

    // Sticky error and failing stage; the oldest attempt (highest stage) wins on a tie.
    always_comb begin
        err_sticky_d = err_sticky_q | f1_s | f2_s | f3_s;
        if (f3_s) begin
            fail_stage_d = 2'd3;
        end else if (f2_s) begin
            fail_stage_d = 2'd2;
        end else if (f1_s) begin
            fail_stage_d = 2'd1;
        end else begin
            fail_stage_d = fail_stage_q;
        end
    end

    // Diagnostic registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            fail_stage_q <= 2'd0;
        end else begin
            err_sticky_q <= err_sticky_d;
            fail_stage_q <= fail_stage_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign fail_stage = fail_stage_q;
`endif

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign active   = s1_q | s2_q | s3_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_fusiont.sv
// Self-checking bench for fusiont. The reference model keeps the full input
// history and decides each edge's outcome by looking back at which attempts
// were launched and what a/b/c were on the cycles that followed. A second
// instance with CNT_W=2 shares the stimulus so counter saturation is checked too.
module tb_fusiont;
    localparam int W  = 16;
    localparam int WS = 2;
    localparam int N  = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, a, b, c;
    logic pass, fail, active;
    logic [W-1:0] pass_cnt, fail_cnt;
    logic pass2, fail2, active2;
    logic [WS-1:0] pass_cnt2, fail_cnt2;
`ifdef FUSIONT_ERR_STICKY_EN
    logic err_sticky, err_sticky2;
    logic [1:0] fail_stage, fail_stage2;
`endif

    fusiont #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
        .pass(pass), .fail(fail), .active(active),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef FUSIONT_ERR_STICKY_EN
        , .err_sticky(err_sticky), .fail_stage(fail_stage)
`endif
    );

    fusiont #(.CNT_W(WS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
        .pass(pass2), .fail(fail2), .active(active2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
`ifdef FUSIONT_ERR_STICKY_EN
        , .err_sticky(err_sticky2), .fail_stage(fail_stage2)
`endif
    );

    bit rs_h[N];
    bit st_h[N];
    bit a_h[N];
    bit b_h[N];
    bit c_h[N];
    int n = 0;
    int checks = 0;
    int errors = 0;
    int tot_p = 0;
    int tot_f = 0;
    bit exp_sticky = 1'b0;
    int exp_stage = 0;

    // An attempt launched at edge t0 is still eligible at edge t if start was
    // sampled high at t0 and no reset edge occurred from t0 through t.
    function automatic bit launched(int t0, int t);
        if (t0 < 0) return 1'b0;
        if (!st_h[t0]) return 1'b0;
        for (int k = t0; k <= t; k++) begin
            if (!rs_h[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then compare against the model.
    task automatic step(bit r, bit s, bit aa, bit bb, bit cc);
        bit pe, f1, f2, f3, act;
        int fc;
        int t;
        rst_n = r; start = s; a = aa; b = bb; c = cc;
        t = n;
        rs_h[t] = r; st_h[t] = s; a_h[t] = aa; b_h[t] = bb; c_h[t] = cc;
        @(posedge clk);
        #1;
        if (!r) begin
            pe = 1'b0; f1 = 1'b0; f2 = 1'b0; f3 = 1'b0; act = 1'b0;
            tot_p = 0; tot_f = 0; exp_sticky = 1'b0; exp_stage = 0;
        end else begin
            pe  = launched(t - 3, t) && a_h[t-2] && b_h[t-1] && c_h[t];
            f1  = launched(t - 1, t) && !a_h[t];
            f2  = launched(t - 2, t) && a_h[t-1] && !b_h[t];
            f3  = launched(t - 3, t) && a_h[t-2] && b_h[t-1] && !c_h[t];
            act = launched(t, t)
               || (launched(t - 1, t) && a_h[t])
               || (launched(t - 2, t) && a_h[t-1] && b_h[t]);
        end
        fc = int'(f1) + int'(f2) + int'(f3);
        tot_p += int'(pe);
        tot_f += fc;
        if (fc > 0) exp_sticky = 1'b1;
        if (f3) exp_stage = 3;
        else if (f2) exp_stage = 2;
        else if (f1) exp_stage = 1;
        chk("pass",      32'(pass),      32'(pe));
        chk("fail",      32'(fail),      32'(fc > 0));
        chk("active",    32'(active),    32'(act));
        chk("pass_cnt",  32'(pass_cnt),  32'(sat(tot_p, W)));
        chk("fail_cnt",  32'(fail_cnt),  32'(sat(tot_f, W)));
        chk("pass2",     32'(pass2),     32'(pe));
        chk("fail2",     32'(fail2),     32'(fc > 0));
        chk("active2",   32'(active2),   32'(act));
        chk("pass_cnt2", 32'(pass_cnt2), 32'(sat(tot_p, WS)));
        chk("fail_cnt2", 32'(fail_cnt2), 32'(sat(tot_f, WS)));
`ifdef FUSIONT_ERR_STICKY_EN
        chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
        chk("fail_stage", 32'(fail_stage), 32'(exp_stage));
        chk("err_sticky2", 32'(err_sticky2), 32'(exp_sticky));
        chk("fail_stage2", 32'(fail_stage2), 32'(exp_stage));
`endif
        n++;
    endtask

    initial begin
        // Reset state, with start held high to show it is ignored.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single passing attempt.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Fail on a.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Fail on c.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Three overlapping passing attempts.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of an attempt.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Five passing attempts drive the narrow counter into saturation.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Simultaneous failures at all three stages in one edge.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Randomized traffic biased towards passing, with rare resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) != 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fusiont.md
Name: fusiont

Overview:
- Synthesizable RTL sequence checker implementing the fused sequence `start |=> (a ##1 b) ##0 (b ##1 c)`, equivalent to `start |=> a ##1 b ##1 c`.
- Tracks overlapping attempts in a 3-stage pipeline and reports per-attempt pass/fail pulses and saturating pass/fail counters.
- Sits beside the control logic it monitors; it is a pure observer and drives nothing back into the design.

Parameters:
- CNT_W, 16: width of pass_cnt and fail_cnt.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launches a new attempt when sampled high.
- a  input  1  must be high 1 cycle after start.
- b  input  1  must be high 2 cycles after start; it is the fusion point shared by both subsequences.
- c  input  1  must be high 3 cycles after start.
- pass  output  1  one-cycle pulse, attempt completed.
- fail  output  1  one-cycle pulse, at least one attempt failed.
- active  output  1  at least one attempt in flight.
- pass_cnt  output  CNT_W  count of passed attempts, saturating.
- fail_cnt  output  CNT_W  count of failed attempts, saturating.

Interface rule: one clock; reset is synchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - s1, s2, s3, pass, fail and both counters go to 0; active=0.
  - start is ignored during reset.
  - Reset mid-operation aborts all in-flight attempts with no pass/fail report.
- Pipeline state, per rising edge with rst_n=1:
  - s1 <= start.
  - s2 <= s1 & a.
  - s3 <= s2 & b.
- Attempt timeline: start sampled at edge T0, a checked at T1, b at T2, c at T3.
- Failure terms, evaluated at each edge:
  - f1 = s1 & !a.
  - f2 = s2 & !b.
  - f3 = s3 & !c.
  - A failing attempt is dropped from the pipeline.
- pass <= s3 & c: registered, high for the one cycle following edge T3.
- fail <= f1 | f2 | f3: registered; a single pulse even when several attempts fail at the same edge.
- Latency:
  - pass: attempt start edge + 3 edges.
  - fail: edge of the first unmet check.
- Overlap: start may be high on consecutive cycles; each cycle is an independent attempt, and up to 3 attempts are in flight.
- active = s1 | s2 | s3, combinational from state.
- Counters:
  - pass_cnt += (s3 & c).
  - fail_cnt += popcount(f1, f2, f3), i.e. 0..3 per edge.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Simultaneous events: a pass and failures of younger attempts at the same edge are all reported; pass and fail may both be 1.
- Inputs are treated as 2-state; any non-1 value counts as 0.
- No vacuous-pass reporting: start=0 produces nothing.

Optional Feature:
FUSIONT_ERR_STICKY_EN
- Defined:
  - Adds output err_sticky (1 bit): set on any fail, cleared only by reset.
  - Adds output fail_stage (2 bits): stage of the most recent failure, 1=a, 2=b, 3=c.
  - On simultaneous failures the highest stage (oldest attempt) is recorded.
  - fail_stage resets to 0.
- Not defined: neither port exists and the behaviour is otherwise identical.

Test Plan:
1. Reset, then start=1 for 1 cycle with a=1, b=1, c=1 on the following cycles -> pass pulses once 3 edges after start; pass_cnt=1, fail_cnt=0, active low afterwards.
2. start=1, then a=0 at T1 -> fail pulse after T1; fail_cnt=1; no pass; active=0 by T2.
3. start=1, a=1, b=1, c=0 at T3 -> fail after T3, pass never; with FUSIONT_ERR_STICKY_EN, fail_stage=3 and err_sticky=1.
4. start=1 for 3 consecutive cycles, a=b=c=1 held -> 3 pass pulses on consecutive cycles; pass_cnt=3; active high for 5 cycles.
5. start=1, a=1, then rst_n=0 at T2 -> no pass/fail; all counters 0; active=0.
6. CNT_W=2, 5 passing attempts -> pass_cnt saturates at 3.
